// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver: FSM state encoding and
// frame bit-order constants.
package serial_word_receiver_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Valid/ready word port between the receiver's holding buffer and its consumer.
interface serial_word_receiver_if #(
    parameter int n = 64
);

    logic [n-1:0] out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/serial_word_receiver_rx_shift_core.sv
// Shift register, bit counter and latched bit order for one incoming frame.
// o_nextWord is the value the register takes on a shift, so the parent can
// capture a complete word on the same edge as the final bit.
module rx_shift_core
    import serial_word_receiver_pkg::*;
#(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic         i_direction,
    input  logic         i_shiftEn,
    input  logic         i_bit,
    output logic [n-1:0] o_nextWord,
    output logic         o_done
);

    localparam int CW = $clog2(n) + 1;

    logic [n-1:0]  r_sreg;
    logic [CW-1:0] r_count;
    logic          r_dir;

    always_comb begin
        if (r_dir == DIR_MSB_FIRST) begin
            o_nextWord = {r_sreg[n-2:0], i_bit};
        end else begin
            o_nextWord = {i_bit, r_sreg[n-1:1]};
        end
        o_done = i_shiftEn && (r_count == CW'(n - 1));
    end

    // The counter returns to zero on the final bit, so it never passes n-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg  <= '0;
            r_count <= '0;
            r_dir   <= DIR_LSB_FIRST;
        end else if (i_start) begin
            r_sreg  <= '0;
            r_count <= '0;
            r_dir   <= i_direction;
        end else if (i_shiftEn) begin
            r_sreg  <= o_nextWord;
            r_count <= o_done ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: frame FSM, one-word holding buffer on a
// valid/ready port, and a sticky overrun flag for dropped words.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int n = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   direction,
    input  logic                   I,
    input  logic                   bit_valid,
    serial_word_receiver_if.master wordPort,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clear_overrun
);

    state_t       r_state;
    state_t       w_nextState;
    logic         w_shiftEn;
    logic         w_done;
    logic [n-1:0] w_nextWord;
    logic         w_bufFree;
    logic         w_load;
    logic         w_drop;
    logic [n-1:0] r_out;
    logic         r_outValid;
    logic         r_overrun;

    assign w_shiftEn = (r_state == ST_SHIFT) && !start && bit_valid;

    rx_shift_core #(
        .n(n)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start),
        .i_direction(direction),
        .i_shiftEn  (w_shiftEn),
        .i_bit      (I),
        .o_nextWord (w_nextWord),
        .o_done     (w_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    w_nextState = ST_SHIFT;
                end else if (w_done) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SHIFT);
    end

    // The buffer counts as free if it is empty or being drained on this edge.
    assign w_bufFree = !r_outValid || wordPort.out_ready;
    assign w_load    = w_done && w_bufFree;
    assign w_drop    = w_done && !w_bufFree;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (w_load) begin
            r_out      <= w_nextWord;
            r_outValid <= 1'b1;
        end else if (r_outValid && wordPort.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign wordPort.out       = r_out;
    assign wordPort.out_valid = r_outValid;
    assign overrun            = r_overrun;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: an n=8 and an n=64 instance share
// the serial inputs; each has its own word port and consumer ready.
module tb_serial_word_receiver;
    import serial_word_receiver_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic direction = 1'b0;
    logic I = 1'b0;
    logic bit_valid = 1'b0;
    logic clear_overrun = 1'b0;
    logic busy8, busy64, overrun8, overrun64;

    int compared = 0;
    int mismatched = 0;

    serial_word_receiver_if #(.n(8))  port8 ();
    serial_word_receiver_if #(.n(64)) port64 ();

    serial_word_receiver #(.n(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .direction    (direction),
        .I            (I),
        .bit_valid    (bit_valid),
        .wordPort     (port8),
        .busy         (busy8),
        .overrun      (overrun8),
        .clear_overrun(clear_overrun)
    );

    serial_word_receiver #(.n(64)) dut64 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .direction    (direction),
        .I            (I),
        .bit_valid    (bit_valid),
        .wordPort     (port64),
        .busy         (busy64),
        .overrun      (overrun64),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled just after each falling edge.
    // A junk bit is offered during the start cycle; it must be ignored.
    task automatic sendFrame(input logic [63:0] word, input int nb, input logic dir,
                             input int gapMode, output int busyLow);
        busyLow = 0;
        start = 1'b1;
        direction = dir;
        bit_valid = 1'b1;
        I = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < nb; k++) begin
            I = dir ? word[nb-1-k] : word[k];
            bit_valid = 1'b1;
            @(negedge clk);
            bit_valid = 1'b0;
            if (k < nb - 1) begin
                if ((nb == 8) ? !busy8 : !busy64) busyLow++;
                repeat (gapMode != 0 ? (k % 4) : 0) begin
                    @(negedge clk);
                    if ((nb == 8) ? !busy8 : !busy64) busyLow++;
                end
            end
        end
    endtask

    task automatic test_reset();
        port8.out_ready = 1'b0;
        port64.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (port8.out !== 8'h00 || port8.out_valid !== 1'b0 || busy8 !== 1'b0 || overrun8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset8: out=%h valid=%b busy=%b ovr=%b required 00/0/0/0", port8.out, port8.out_valid, busy8, overrun8);
        end
        compared++;
        if (port64.out !== 64'h0 || port64.out_valid !== 1'b0 || busy64 !== 1'b0 || overrun64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset64: out=%h valid=%b busy=%b ovr=%b required 0/0/0/0", port64.out, port64.out_valid, busy64, overrun64);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [7:0] word = 8'hA5;
        port8.out_ready = 1'b1;
        start = 1'b1;
        direction = DIR_LSB_FIRST;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            I = word[k];
            bit_valid = 1'b1;
            @(negedge clk);
            bit_valid = 0;
            if (k < 7) begin
                compared++;
                if (port8.out_valid !== 1'b0 || busy8 !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL lsb_midframe bit %0d: valid=%b busy=%b required 0/1", k, port8.out_valid, busy8);
                end
            end
        end
        compared++;
        if (port8.out !== 8'hA5 || port8.out_valid !== 1'b1 || busy8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lsb_word: out=%h valid=%b busy=%b required a5/1/0", port8.out, port8.out_valid, busy8);
        end
        @(negedge clk);
        compared++;
        if (port8.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lsb_transfer: valid=%b required 0", port8.out_valid);
        end
    endtask

    task automatic test_msb_gaps();
        int busyLow;
        port8.out_ready = 1'b1;
        sendFrame(64'hA5, 8, DIR_MSB_FIRST, 0, busyLow);
        compared++;
        if (port8.out !== 8'hA5 || port8.out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL msb_word: out=%h valid=%b required a5/1", port8.out, port8.out_valid);
        end
        @(negedge clk);
        sendFrame(64'hA5, 8, DIR_MSB_FIRST, 1, busyLow);
        compared++;
        if (port8.out !== 8'hA5 || port8.out_valid !== 1'b1 || busyLow !== 0) begin
            mismatched++;
            $display("[TB] FAIL msb_gaps: out=%h valid=%b busyLowCycles=%0d required a5/1/0", port8.out, port8.out_valid, busyLow);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int busyLow;
        port8.out_ready = 1'b0;
        sendFrame(64'h3C, 8, DIR_LSB_FIRST, 0, busyLow);
        compared++;
        if (port8.out !== 8'h3C || port8.out_valid !== 1'b1 || overrun8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovr_first: out=%h valid=%b ovr=%b required 3c/1/0", port8.out, port8.out_valid, overrun8);
        end
        sendFrame(64'h5A, 8, DIR_LSB_FIRST, 1, busyLow);
        compared++;
        if (port8.out !== 8'h3C || port8.out_valid !== 1'b1 || overrun8 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovr_drop: out=%h valid=%b ovr=%b required 3c/1/1", port8.out, port8.out_valid, overrun8);
        end
        port8.out_ready = 1'b1;
        @(negedge clk);
        port8.out_ready = 1'b0;
        compared++;
        if (port8.out_valid !== 1'b0 || overrun8 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovr_drain: valid=%b ovr=%b required 0/1", port8.out_valid, overrun8);
        end
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        compared++;
        if (overrun8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovr_clear: ovr=%b required 0", overrun8);
        end
        // A drop on the same edge as a clear must leave the flag set.
        sendFrame(64'h96, 8, DIR_MSB_FIRST, 0, busyLow);
        clear_overrun = 1'b1;
        sendFrame(64'h69, 8, DIR_MSB_FIRST, 0, busyLow);
        clear_overrun = 1'b0;
        compared++;
        if (port8.out !== 8'h96 || overrun8 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovr_drop_beats_clear: out=%h ovr=%b required 96/1", port8.out, overrun8);
        end
        port8.out_ready = 1'b1;
        clear_overrun = 1'b1;
        @(negedge clk);
        port8.out_ready = 1'b0;
        clear_overrun = 1'b0;
    endtask

    task automatic test_back_to_back();
        int busyLow;
        logic [7:0] word = 8'h22;
        port8.out_ready = 1'b0;
        sendFrame(64'h11, 8, DIR_LSB_FIRST, 0, busyLow);
        start = 1'b1;
        direction = DIR_LSB_FIRST;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            I = word[k];
            bit_valid = 1'b1;
            if (k == 7) port8.out_ready = 1'b1;
            @(negedge clk);
            bit_valid = 1'b0;
            if (k == 6) begin
                compared++;
                if (port8.out !== 8'h11 || port8.out_valid !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_stall: out=%h valid=%b required 11/1", port8.out, port8.out_valid);
                end
            end
        end
        compared++;
        if (port8.out !== 8'h22 || port8.out_valid !== 1'b1 || overrun8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_reload: out=%h valid=%b ovr=%b required 22/1/0", port8.out, port8.out_valid, overrun8);
        end
        @(negedge clk);
    endtask

    task automatic test_restart();
        int busyLow;
        port8.out_ready = 1'b1;
        start = 1'b1;
        direction = DIR_LSB_FIRST;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            I = 1'b1;
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        compared++;
        if (port8.out_valid !== 1'b0 || busy8 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL restart_partial: valid=%b busy=%b required 0/1", port8.out_valid, busy8);
        end
        sendFrame(64'hC3, 8, DIR_MSB_FIRST, 0, busyLow);
        compared++;
        if (port8.out !== 8'hC3 || port8.out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL restart_word: out=%h valid=%b required c3/1", port8.out, port8.out_valid);
        end
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (port8.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL restart_single: valid=%b required 0", port8.out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        int busyLow;
        port64.out_ready = 1'b0;
        sendFrame(64'hFEDC_BA98_7654_3210, 64, DIR_LSB_FIRST, 0, busyLow);
        compared++;
        if (port64.out !== 64'hFEDC_BA98_7654_3210 || port64.out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL w64_first: out=%h valid=%b required fedcba9876543210/1", port64.out, port64.out_valid);
        end
        start = 1'b1;
        direction = DIR_LSB_FIRST;
        @(negedge clk);
        start = 1'b0;
        repeat (30) begin
            I = 1'b1;
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        compared++;
        if (busy64 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL w64_busy: busy=%b required 1", busy64);
        end
        #2;
        reset = 1'b0;
        #1;
        compared++;
        if (port64.out !== 64'h0 || port64.out_valid !== 1'b0 || busy64 !== 1'b0 || overrun64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL w64_async_reset: out=%h valid=%b busy=%b ovr=%b required 0/0/0/0", port64.out, port64.out_valid, busy64, overrun64);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sendFrame(64'h0123_4567_89AB_CDEF, 64, DIR_LSB_FIRST, 0, busyLow);
        compared++;
        if (port64.out !== 64'h0123_4567_89AB_CDEF || port64.out_valid !== 1'b1 || busyLow !== 0) begin
            mismatched++;
            $display("[TB] FAIL w64_word: out=%h valid=%b busyLowCycles=%0d required 0123456789abcdef/1/0", port64.out, port64.out_valid, busyLow);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_gaps();
        test_overrun();
        test_back_to_back();
        test_restart();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver; the receiving end of the team's serial shift-register link.
- Captures n serial bits, either LSB-first or MSB-first, and assembles them into an n-bit word.
- Presents the word on a valid/ready output port backed by a one-word holding buffer, so the next frame can arrive while the consumer stalls.
- Sits between the serial link and the 64-bit datapath (adder/register file side).

Parameters:
- n, 64, word width in bits; must be >= 2.
- CW, $clog2(n)+1, bit-counter width; derived localparam, not user-set.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  frame start strobe; arms or restarts reception
- direction  input  1  0 = LSB-first, 1 = MSB-first; sampled only when start is accepted
- I  input  1  serial data bit
- bit_valid  input  1  I is valid this cycle
- out  output  n  received word (holding buffer)
- out_valid  output  1  out holds an unconsumed word
- out_ready  input  1  consumer accepts out this cycle
- busy  output  1  frame in progress (state SHIFT)
- overrun  output  1  sticky flag: a completed word was dropped
- clear_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, bit count and out all 0.
  - out_valid=0, busy=0, overrun=0.
  - A reset mid-frame discards the partial frame and any buffered word.
- FSM states: IDLE, SHIFT.
- IDLE:
  - start=1 -> SHIFT next edge; count cleared, dir_q<=direction, shift register cleared.
  - bit_valid is ignored in the cycle start is accepted.
- SHIFT:
  - start=1 -> restart: count<=0, shift register cleared, dir_q re-sampled; bit_valid that cycle is ignored; stay in SHIFT.
  - Else, on bit_valid=1, capture I:
    - dir_q=0 (LSB-first): sreg <= {I, sreg[n-1:1]}, so the k-th bit lands in out[k].
    - dir_q=1 (MSB-first): sreg <= {sreg[n-2:0], I}, so the first bit lands in out[n-1].
    - count increments.
  - bit_valid=0 -> hold state, no shift; gaps of any length are legal.
  - When the n-th bit is captured (count==n-1 with bit_valid=1) -> IDLE and a word-complete event fires.
- busy = (state==SHIFT).
- Word-complete event, evaluated on the same edge that captures the n-th bit:
  - The complete word (the shifted value including the n-th bit) is written to out if the buffer is free after this cycle's handshake, i.e. !out_valid or out_ready.
    - out_valid=1 from the next cycle: latency is 1 edge after the last bit.
  - If out_valid=1 and out_ready=0: the word is dropped, out is unchanged, and overrun<=1.
- Handshake:
  - Transfer occurs on an edge where out_valid && out_ready.
  - out_valid falls after a transfer unless a word completes on that same edge, in which case out loads the new word and out_valid stays 1.
  - out and out_valid are stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
- overrun is sticky:
  - clear_overrun=1 clears it on the next edge.
  - If a new drop occurs on the same edge as clear_overrun=1, the drop wins and overrun stays 1.
- n is a compile-time parameter; a frame always has exactly n bits; the counter never wraps past n-1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0, ST_SHIFT=1;
  - direction constants DIR_LSB_FIRST=0, DIR_MSB_FIRST=1.
- One sub-module: rx_shift_core, containing the shift register, bit counter and dir_q, with a done pulse output.
- The parent holds the FSM, the output buffer and overrun logic.

Test Plan:
- n=8, start with direction=0, then bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 -> out=8'hA5, out_valid=1 exactly one edge after the 8th bit, busy low after the 8th bit.
- n=8, direction=1, same bit sequence -> out=8'hA5; repeat with bit_valid gaps of 0-3 cycles between bits -> same result, busy held throughout.
- n=8, out_ready=0, frame 8'h3C then frame 8'h5A -> out stays 8'h3C, overrun=1; then out_ready=1 for one cycle -> out_valid=0; assert clear_overrun -> overrun=0.
- n=8, out_valid=1 holding 8'h11, out_ready=1 on the same edge frame 8'h22 completes -> out=8'h22, out_valid stays 1, overrun=0.
- n=8, start, 4 bits, start again with direction=1, then 8 bits forming 8'hC3 -> out=8'hC3, and no word is produced from the aborted 4 bits.
- n=64: drive reset=0 asynchronously mid-frame after 30 bits -> all outputs 0 immediately; after release, a 64-bit frame 64'h0123_4567_89AB_CDEF (LSB-first) -> out matches.
